// File: rtl/inert_spi_seq_pkg.sv
// Shared types and helpers for the inertial-sensor SPI sequencer.
package inert_pkg;

  // Sequencer states, in the order a power-up walks through them.
  typedef enum logic [2:0] {
    PWRUP    = 3'd0,
    INIT     = 3'd1,
    INIT_FIN = 3'd2,
    WAIT_INT = 3'd3,
    READ     = 3'd4,
    PUBLISH  = 3'd5
  } state_t;

  // Bit of the SPI command word that selects a register read.
  localparam int RD_BIT = 15;

  // Build a single-register read command: read flag, 7-bit address, dummy byte.
  function automatic logic [15:0] mk_rd_cmd(input logic [6:0] addr7);
    logic [15:0] c;
    c         = 16'h0000;
    c[RD_BIT] = 1'b1;
    c[14:8]   = addr7;
    return c;
  endfunction

endpackage

// File: rtl/inert_spi_seq.sv
// Inertial-sensor sequencer: power-up wait, init write list, then per-INT
// frame reads of NUM_CH 16-bit channels published atomically with vld.
//
// SPI handshake with the external master: wrt is a one-cycle start pulse
// that carries cmd in the same cycle; the master answers with a one-cycle
// done pulse (rd_data valid with it). At most one transaction is in flight,
// tracked by spi_idle (cleared when wrt pulses, set on done). In READ the
// next wrt is issued in the very cycle done arrives, so bytes of a frame
// go back-to-back.
module inert_spi_seq
  import inert_pkg::*;
#(
  parameter int NUM_INIT = 4,
  parameter int NUM_CH   = 2,
  parameter int PWR_W    = 16,
  parameter int GAP_W    = 10,
  parameter int TO_W     = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   INT,
  input  logic                   done,
  input  logic [15:0]            rd_data,
  input  logic [NUM_INIT*16-1:0] init_cmd,
  input  logic [NUM_CH*7-1:0]    ch_addr,
  output logic                   wrt,
  output logic [15:0]            cmd,
  output logic [NUM_CH*16-1:0]   ch_data,
  output logic                   vld,
  output logic                   err,
  output logic                   init_done,
  output state_t                 dbg_state
);

  localparam logic [4:0] IDX_LAST = 5'(NUM_INIT - 1);
  localparam logic [3:0] K_LAST   = 4'(2 * NUM_CH - 1);

  state_t                 state_q, state_d;
  logic [PWR_W-1:0]       pwr_q, pwr_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic [4:0]             idx_q, idx_d;
  logic [3:0]             k_q, k_d;
  logic                   spi_idle_q, spi_idle_d;
  logic                   wrt_q, wrt_d;
  logic [15:0]            cmd_q, cmd_d;
  logic                   vld_q, vld_d;
  logic                   err_q, err_d;
  logic                   init_done_q, init_done_d;
  logic [NUM_CH*16-1:0]   ch_data_q, ch_data_d;
  logic [NUM_CH*16-1:0]   stage_q, stage_d;
  logic                   int_meta_q, int_s_q;

  // Only the low byte of each read word carries register data.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:8];

  // Read command for frame byte k: even k is the channel's low-byte address,
  // odd k the next address (7-bit add wraps modulo 128).
  function automatic logic [15:0] byte_cmd(input logic [3:0] k);
    logic [6:0] a;
    a = ch_addr[7*int'(k[3:1]) +: 7] + {6'd0, k[0]};
    return mk_rd_cmd(a);
  endfunction

  // Two-flop synchroniser for the asynchronous INT line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_meta_q <= 1'b0;
      int_s_q    <= 1'b0;
    end else begin
      int_meta_q <= INT;
      int_s_q    <= int_meta_q;
    end
  end

  // Next-state and next-output logic of the sequencer.
  always_comb begin
    state_d     = state_q;
    pwr_d       = pwr_q;
    gap_d       = gap_q;
    to_d        = to_q;
    idx_d       = idx_q;
    k_d         = k_q;
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    vld_d       = 1'b0;
    err_d       = err_q;
    init_done_d = init_done_q;
    ch_data_d   = ch_data_q;
    stage_d     = stage_q;
    spi_idle_d  = spi_idle_q | done;

    case (state_q)
      PWRUP: begin
        pwr_d = pwr_q + 1'b1;
        if (&pwr_q) begin
          state_d = INIT;
          idx_d   = 5'd0;
          gap_d   = '0;
        end
      end
      INIT: begin
        if ((&gap_q) && spi_idle_q) begin
          wrt_d = 1'b1;
          cmd_d = init_cmd[16*int'(idx_q) +: 16];
          idx_d = idx_q + 1'b1;
          gap_d = '0;
          if (idx_q == IDX_LAST) state_d = INIT_FIN;
        end else if (!(&gap_q)) begin
          // The gap holds at all ones while the previous write is still busy.
          gap_d = gap_q + 1'b1;
        end
      end
      INIT_FIN: begin
        if (done) begin
          init_done_d = 1'b1;
          to_d        = '0;
          state_d     = WAIT_INT;
        end
      end
      WAIT_INT: begin
        // A frame start takes priority over a timeout in the same cycle.
        if (int_s_q) begin
          wrt_d   = 1'b1;
          cmd_d   = byte_cmd(4'd0);
          k_d     = 4'd0;
          state_d = READ;
        end else if (&to_q) begin
          err_d = 1'b1;
          to_d  = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      READ: begin
        if (done) begin
          stage_d[8*int'(k_q) +: 8] = rd_data[7:0];
          if (k_q != K_LAST) begin
            wrt_d = 1'b1;
            cmd_d = byte_cmd(k_q + 1'b1);
            k_d   = k_q + 1'b1;
          end else begin
            state_d = PUBLISH;
          end
        end
      end
      PUBLISH: begin
        ch_data_d = stage_q;
        vld_d     = 1'b1;
        err_d     = 1'b0;
        to_d      = '0;
        state_d   = WAIT_INT;
      end
      default: state_d = PWRUP;
    endcase

    // Issuing a transaction always marks the master busy, even if a done
    // for the previous one lands in the same cycle.
    if (wrt_d) spi_idle_d = 1'b0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWRUP;
      pwr_q       <= '0;
      gap_q       <= '0;
      to_q        <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      spi_idle_q  <= 1'b1;
      wrt_q       <= 1'b0;
      cmd_q       <= '0;
      vld_q       <= 1'b0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
      ch_data_q   <= '0;
      stage_q     <= '0;
    end else begin
      state_q     <= state_d;
      pwr_q       <= pwr_d;
      gap_q       <= gap_d;
      to_q        <= to_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      spi_idle_q  <= spi_idle_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
      ch_data_q   <= ch_data_d;
      stage_q     <= stage_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign vld       = vld_q;
  assign err       = err_q;
  assign init_done = init_done_q;
  assign ch_data   = ch_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_inert_spi_seq.sv
// Directed bench for inert_spi_seq with a small SPI master model that
// answers every wrt with a done pulse 20 cycles later.
module tb_inert_spi_seq;
  import inert_pkg::*;

  localparam int NUM_INIT = 2;
  localparam int NUM_CH   = 2;
  localparam int PWR_W    = 4;
  localparam int GAP_W    = 3;
  localparam int TO_W     = 6;
  // Reset release -> first wrt edge: 16 power-up edges, 7 gap increments,
  // then the issuing edge.
  localparam int FIRST_WRT = (1 << PWR_W) + (1 << GAP_W);

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   int_in = 1'b0;
  logic                   done = 1'b0;
  logic [15:0]            rd_data = 16'h0000;
  logic [NUM_INIT*16-1:0] init_cmd;
  logic [NUM_CH*7-1:0]    ch_addr;
  logic                   wrt;
  logic [15:0]            cmd;
  logic [NUM_CH*16-1:0]   ch_data;
  logic                   vld;
  logic                   err;
  logic                   init_done;
  state_t                 dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // SPI model bookkeeping
  logic [15:0] obs_cmd[$];
  int          obs_cyc[$];
  logic [7:0]  byte_q[$];
  logic [15:0] exp_q[$];
  int          cnt = 0;
  bit          pend_rd = 1'b0;
  int          n_done = 0;
  int          done_edge = 0;

  inert_spi_seq #(
    .NUM_INIT(NUM_INIT), .NUM_CH(NUM_CH), .PWR_W(PWR_W), .GAP_W(GAP_W), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .INT(int_in), .done(done), .rd_data(rd_data),
    .init_cmd(init_cmd), .ch_addr(ch_addr), .wrt(wrt), .cmd(cmd),
    .ch_data(ch_data), .vld(vld), .err(err), .init_done(init_done),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model: log each command, pulse done 20 edges after wrt.
  always @(negedge clk) begin
    if (!rst_n) begin
      done = 1'b0;
      cnt  = 0;
    end else begin
      done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          done = 1'b1;
          n_done++;
          done_edge = cyc + 1;
          if (pend_rd)
            rd_data = {8'hA5, (byte_q.size() > 0) ? byte_q.pop_front() : 8'hEE};
          else
            rd_data = 16'h5A5A;
        end
      end
      if (wrt) begin
        obs_cmd.push_back(cmd);
        obs_cyc.push_back(cyc);
        pend_rd = cmd[15];
        cnt     = 19;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_cmds(input int n, input int max_cyc);
    int t;
    t = 0;
    while (obs_cmd.size() < n && t < max_cyc) begin
      step();
      t++;
    end
    chk("wait_cmds", 64'(obs_cmd.size() >= n), 64'd1);
  endtask

  task automatic wait_vld(input logic [31:0] hold, output int vcyc);
    int t;
    bit bad;
    t = 0;
    bad = 1'b0;
    vcyc = -1;
    while (t < 400) begin
      step();
      t++;
      if (vld) begin
        vcyc = cyc;
        break;
      end
      if (ch_data !== hold) bad = 1'b1;
    end
    chk("vld_seen", 64'(vcyc >= 0), 64'd1);
    chk("ch_data_hold", 64'(bad), 64'd0);
  endtask

  // Pop four frame commands and compare against the expected queue; the
  // bytes of a frame must be spaced exactly one transaction (20 cycles).
  task automatic check_frame_cmds(output int first_cyc);
    logic [15:0] c;
    logic [15:0] e;
    int          t;
    int          prev;
    first_cyc = -1;
    prev = 0;
    for (int i = 0; i < 2 * NUM_CH; i++) begin
      c = obs_cmd.pop_front();
      t = obs_cyc.pop_front();
      e = exp_q.pop_front();
      chk("frame_cmd", 64'(c), 64'(e));
      if (i == 0) first_cyc = t;
      else chk("frame_b2b", 64'(t - prev), 64'd20);
      prev = t;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wrt"}, 64'(wrt), 64'd0);
    chk({tag, "_cmd"}, 64'(cmd), 64'd0);
    chk({tag, "_vld"}, 64'(vld), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_init_done"}, 64'(init_done), 64'd0);
    chk({tag, "_ch_data"}, 64'(ch_data), 64'd0);
  endtask

  // Hard stop if something never completes.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int rel, w, c0, v1, v2, f;
    init_cmd = {16'h1053, 16'h0D02};
    ch_addr  = {7'h2C, 7'h22};

    // ---- reset state
    repeat (3) step();
    check_all_zero("rst");
    chk("rst_state", 64'(dbg_state), 64'(PWRUP));

    // ---- power-up and init writes
    rst_n = 1'b1;
    rel = cyc;
    wait_cmds(1, 100);
    chk("init0_cmd", 64'(obs_cmd[0]), 64'h0D02);
    chk("init0_cyc", 64'(obs_cyc[0] - rel), 64'(FIRST_WRT));
    wait_cmds(2, 200);
    chk("init1_cmd", 64'(obs_cmd[1]), 64'h1053);
    chk("init1_gap_min", 64'((obs_cyc[1] - obs_cyc[0]) >= 8), 64'd1);
    // First done at +20, spi_idle seen the edge after.
    chk("init1_after_done", 64'(obs_cyc[1] - obs_cyc[0]), 64'd21);
    w = obs_cyc[1] + 20;
    wait_until_cyc(w - 1);
    chk("init_done_before", 64'(init_done), 64'd0);
    wait_until_cyc(w);
    chk("init_done_rise", 64'(init_done), 64'd1);
    void'(obs_cmd.pop_front()); void'(obs_cmd.pop_front());
    void'(obs_cyc.pop_front()); void'(obs_cyc.pop_front());

    // ---- INT timeout: counter hits all ones on the 64th WAIT_INT edge
    wait_until_cyc(w + 63);
    chk("err_before_to", 64'(err), 64'd0);
    wait_until_cyc(w + 64);
    chk("err_at_to", 64'(err), 64'd1);
    wait_until_cyc(w + 100);
    chk("err_sticky", 64'(err), 64'd1);
    chk("no_reads_idle", 64'(obs_cmd.size()), 64'd0);

    // ---- frame 1 (INT stays high so frame 2 follows immediately)
    byte_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_q  = {16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
    c0 = cyc;
    int_in = 1'b1;
    wait_vld(32'h0, v1);
    chk("f1_ch_data", 64'(ch_data), 64'h44332211);
    chk("f1_err_clr", 64'(err), 64'd0);
    chk("f1_vld_lat", 64'(v1), 64'(done_edge + 1));
    check_frame_cmds(f);
    chk("f1_int_sync", 64'(f), 64'(c0 + 3));
    step();
    chk("f1_vld_pulse", 64'(vld), 64'd0);
    int_in = 1'b0;

    // ---- frame 2: level-sensitive restart, atomic update
    exp_q = {16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
    wait_vld(32'h44332211, v2);
    chk("f2_ch_data", 64'(ch_data), 64'h88776655);
    chk("f2_vld_lat", 64'(v2), 64'(done_edge + 1));
    check_frame_cmds(f);
    chk("f2_restart", 64'(f), 64'(v1 + 1));
    repeat (10) step();
    chk("no_frame3", 64'(obs_cmd.size()), 64'd0);

    // ---- address wrap, then reset mid-frame
    ch_addr = {7'h2C, 7'h7F};
    byte_q  = {8'h01, 8'h02, 8'h03, 8'h04};
    f = n_done;
    int_in = 1'b1;
    wait_cmds(2, 100);
    chk("wrap_lo", 64'(obs_cmd[0]), 64'hFF00);
    chk("wrap_hi", 64'(obs_cmd[1]), 64'h8000);
    c0 = 0;
    while (n_done < f + 2 && c0 < 200) begin
      step();
      c0++;
    end
    chk("f3_two_dones", 64'(n_done), 64'(f + 2));
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    int_in = 1'b0;
    repeat (3) step();
    obs_cmd.delete();
    obs_cyc.delete();
    byte_q.delete();
    rst_n = 1'b1;
    rel = cyc;
    wait_cmds(1, 100);
    chk("restart_cmd", 64'(obs_cmd[0]), 64'h0D02);
    chk("restart_cyc", 64'(obs_cyc[0] - rel), 64'(FIRST_WRT));
    chk("restart_init_done", 64'(init_done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
